uesprit_frame_buffer: RTL and testbench
=======================================

Name: uesprit_frame_buffer

Overview:
- Sits directly downstream of the vector U-ESPRIT correlator stage.
- Consumes its per-channel correlation stream (r11, r22, r12_re, one channel per valid cycle, VECTOR_LEN channels per accumulation) and forms the two atan2 arguments of the 2-element U-ESPRIT angle:
  - diff = r11 - r22
  - cross = 2*r12_re
- Stores one full frame in a ping-pong buffer so software/readout logic can fetch a stable, complete frame while the next one is written.

Parameters:
- VECTOR_LEN, 512, channels per frame; power of two, >= 4.
- DIN_WIDTH, 32, width of the signed correlator words r11/r22/r12_re.
- ADDR_WIDTH, $clog2(VECTOR_LEN), derived localparam; read address width.
- DROP_WIDTH, 16, width of dropped-frame counter.

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- rst, input, 1, synchronous active-high reset.
- r11, input, DIN_WIDTH, signed auto-correlation element 1.
- r22, input, DIN_WIDTH, signed auto-correlation element 2.
- r12_re, input, DIN_WIDTH, signed real cross-correlation.
- din_valid, input, 1, qualifies r11/r22/r12_re; one channel per asserted cycle.
- rd_en, input, 1, read request for rd_addr in the completed bank.
- rd_addr, input, ADDR_WIDTH, channel index to read.
- rd_done, input, 1, one-cycle pulse: reader has released the completed bank.
- rd_diff, output, DIN_WIDTH+1, signed r11-r22 for the read channel.
- rd_cross, output, DIN_WIDTH+1, signed 2*r12_re for the read channel.
- rd_valid, output, 1, rd_diff/rd_cross valid.
- frame_ready, output, 1, a complete frame is held for reading.
- frame_count, output, 32, frames successfully handed to the reader.
- drop_count, output, DROP_WIDTH, frames discarded because the reader had not released.

Behaviour:
- Arithmetic:
  - diff is computed as (DIN_WIDTH+1)-bit sign-extended subtraction.
  - cross is r12_re sign-extended and shifted left 1.
  - Both are exact; no rounding or saturation.
  - Stored word per channel is 2*(DIN_WIDTH+1) bits; memory is 2 banks x VECTOR_LEN.
- Write side:
  - wr_ptr (ADDR_WIDTH) counts din_valid cycles.
  - Each valid sample is written at wr_ptr in bank wr_bank one cycle after capture (one input register stage).
  - wr_ptr wraps VECTOR_LEN-1 -> 0.
  - Gaps in din_valid are allowed; the write pointer only advances on valid cycles.
- Frame completion: the cycle the sample at wr_ptr == VECTOR_LEN-1 is committed.
  - If frame_ready == 0:
    - rd_bank <= wr_bank, wr_bank toggles.
    - frame_ready <= 1, frame_count += 1.
  - If frame_ready == 1:
    - No swap; the next frame overwrites the same write bank.
    - drop_count += 1, saturating at all-ones.
  - Simultaneous rd_done and completion: rd_done is applied first, so the swap occurs and frame_ready stays 1.
- rd_done:
  - Clears frame_ready next cycle.
  - rd_done while frame_ready == 0 is ignored.
- Read side:
  - Registered address, synchronous memory read.
  - rd_valid = rd_en delayed 2 cycles.
  - rd_diff/rd_cross update 2 cycles after rd_en.
  - Reads use rd_bank as of the rd_en cycle.
  - rd_en while frame_ready == 0 still returns the rd_bank contents, stale or zero.
  - Read and write never target the same bank while frame_ready == 1.
- Reset values and behaviour:
  - All outputs reset to 0: rd_valid, frame_ready, frame_count, drop_count, rd_diff, rd_cross.
  - Internal state resets: wr_ptr = 0, wr_bank = 0, rd_bank = 1, read pipeline flushed.
  - Memory contents are not cleared.
  - Reset mid-frame discards the partial frame; the next din_valid is channel 0.

Test Plan:
- VECTOR_LEN=8, rst then 8 valid samples r11=100+k, r22=40, r12_re=-3 -> frame_ready=1 one cycle after last commit, frame_count=1; reads addr 0..7 give rd_diff=60+k, rd_cross=-6, rd_valid 2 cycles after each rd_en.
- Extremes r11=0x7FFFFFFF, r22=0x80000000, r12_re=0x80000000 -> rd_diff=+4294967295 (33-bit), rd_cross=-4294967296, no overflow.
- Two frames with no rd_done -> frame_count=1, drop_count=1; reads still return frame 1 data; rd_done then a third frame -> frame_count=2, returns frame 3 data.
- rd_done asserted in the same cycle as frame 2 completes -> frame_ready stays 1, frame_count=2, reads return frame 2.
- din_valid toggling 1-0-1 for 8 valid samples -> exactly one frame, channel order preserved.
- rst after 5 samples, then 8 fresh samples -> frame_count=1, addr 0 holds the first post-reset sample, all outputs were 0 during reset.

Source files
------------

// File: rtl/uesprit_frame_buffer.sv
// Ping-pong frame buffer for the U-ESPRIT correlator stream: forms diff = r11 - r22 and
// cross = 2*r12_re per channel and holds one complete frame stable for the reader.
module uesprit_frame_buffer #(
    parameter int VECTOR_LEN = 512,
    parameter int DIN_WIDTH  = 32,
    parameter int DROP_WIDTH = 16,
    localparam int ADDR_WIDTH = $clog2(VECTOR_LEN)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DIN_WIDTH-1:0]   r11,
    input  logic [DIN_WIDTH-1:0]   r22,
    input  logic [DIN_WIDTH-1:0]   r12_re,
    input  logic                   din_valid,
    input  logic                   rd_en,
    input  logic [ADDR_WIDTH-1:0]  rd_addr,
    input  logic                   rd_done,
    output logic [DIN_WIDTH:0]     rd_diff,
    output logic [DIN_WIDTH:0]     rd_cross,
    output logic                   rd_valid,
    output logic                   frame_ready,
    output logic [31:0]            frame_count,
    output logic [DROP_WIDTH-1:0]  drop_count
);

    localparam int OUT_WIDTH = DIN_WIDTH + 1;
    localparam int WORD_WIDTH = 2 * OUT_WIDTH;
    localparam int DEPTH = 2 * VECTOR_LEN;
    localparam logic [ADDR_WIDTH-1:0] LAST_CH = ADDR_WIDTH'(VECTOR_LEN - 1);

    // Handshake: din_valid and rd_en are single-cycle qualifiers with no backpressure;
    // every asserted cycle is consumed. rd_valid follows rd_en by exactly two cycles.

    // Input register stage
    logic                  s_valid;
    logic [OUT_WIDTH-1:0]  s_diff;
    logic [OUT_WIDTH-1:0]  s_cross;

    // Write side and bank control
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic                  wr_bank;
    logic                  rd_bank;

    // Read pipeline
    logic                  rd_en_q;
    logic [ADDR_WIDTH:0]   rd_addr_q;

    logic [WORD_WIDTH-1:0] mem [DEPTH];

    logic [OUT_WIDTH-1:0]  diff_next;
    logic [OUT_WIDTH-1:0]  cross_next;
    logic                  release_bank;
    logic                  frame_done;
    logic                  do_swap;
    logic [WORD_WIDTH-1:0] rd_word;

    always_comb begin
        diff_next    = {r11[DIN_WIDTH-1], r11} - {r22[DIN_WIDTH-1], r22};
        cross_next   = {r12_re, 1'b0};
        release_bank = rd_done && frame_ready;
        frame_done   = s_valid && (wr_ptr == LAST_CH);
        // A release in the completion cycle frees the read bank before the swap decision.
        do_swap      = frame_done && (!frame_ready || release_bank);
        rd_word      = mem[rd_addr_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_valid <= 1'b0;
            s_diff  <= '0;
            s_cross <= '0;
        end else begin
            s_valid <= din_valid;
            if (din_valid) begin
                s_diff  <= diff_next;
                s_cross <= cross_next;
            end
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (s_valid) begin
            mem[{wr_bank, wr_ptr}] <= {s_diff, s_cross};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b1;
            frame_ready <= 1'b0;
            frame_count <= '0;
            drop_count  <= '0;
        end else begin
            if (s_valid) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (do_swap) begin
                rd_bank     <= wr_bank;
                wr_bank     <= ~wr_bank;
                frame_ready <= 1'b1;
                frame_count <= frame_count + 32'd1;
            end else if (frame_done) begin
                // Reader still holds its bank: the finished frame is overwritten next time.
                if (drop_count != {DROP_WIDTH{1'b1}}) begin
                    drop_count <= drop_count + DROP_WIDTH'(1);
                end
            end else if (release_bank) begin
                frame_ready <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_valid  <= 1'b0;
            rd_diff   <= '0;
            rd_cross  <= '0;
        end else begin
            rd_en_q   <= rd_en;
            rd_addr_q <= {rd_bank, rd_addr};
            rd_valid  <= rd_en_q;
            if (rd_en_q) begin
                rd_diff  <= rd_word[WORD_WIDTH-1:OUT_WIDTH];
                rd_cross <= rd_word[OUT_WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_uesprit_frame_buffer.sv
// Directed bench for uesprit_frame_buffer (VECTOR_LEN=8): reads are scoreboarded through an
// expected queue checked by a separate monitor; frame/count state is checked inline.
module tb_uesprit_frame_buffer;

    localparam int VL = 8;
    localparam int DW = 32;
    localparam int AW = 3;
    localparam int DRW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [DW-1:0]   r11 = '0;
    logic [DW-1:0]   r22 = '0;
    logic [DW-1:0]   r12_re = '0;
    logic            din_valid = 1'b0;
    logic            rd_en = 1'b0;
    logic [AW-1:0]   rd_addr = '0;
    logic            rd_done = 1'b0;
    logic [DW:0]     rd_diff;
    logic [DW:0]     rd_cross;
    logic            rd_valid;
    logic            frame_ready;
    logic [31:0]     frame_count;
    logic [DRW-1:0]  drop_count;

    uesprit_frame_buffer #(.VECTOR_LEN(VL), .DIN_WIDTH(DW), .DROP_WIDTH(DRW)) dut (
        .clk(clk), .rst(rst), .r11(r11), .r22(r22), .r12_re(r12_re),
        .din_valid(din_valid), .rd_en(rd_en), .rd_addr(rd_addr), .rd_done(rd_done),
        .rd_diff(rd_diff), .rd_cross(rd_cross), .rd_valid(rd_valid),
        .frame_ready(frame_ready), .frame_count(frame_count), .drop_count(drop_count)
    );

    // clock / reset block
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [2*(DW+1)-1:0] exp_q[$];
    int iss_q[$];

    task automatic check(input string nm, input logic [2*(DW+1)-1:0] act, input logic [2*(DW+1)-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Hand-written vectors: stimulus and expected {diff, cross} per frame mode and channel.
    task automatic gen(input int mode, input int k, output logic [DW-1:0] a, output logic [DW-1:0] b,
                       output logic [DW-1:0] c, output logic [2*(DW+1)-1:0] e);
        logic signed [DW:0] d;
        logic signed [DW:0] x;
        case (mode)
            0: begin a = 100 + k; b = 40; c = -3; d = 60 + k; x = -6; end
            1: begin
                if (k % 2 == 0) begin
                    a = 32'h7FFF_FFFF; b = 32'h8000_0000; c = 32'h8000_0000;
                    d = 33'h0_FFFF_FFFF; x = 33'h1_0000_0000;
                end else begin
                    a = -5; b = 7; c = 1000; d = -12; x = 2000;
                end
            end
            2: begin a = 1000 + k; b = 0; c = k; d = 1000 + k; x = 2 * k; end
            3: begin a = 2000 + k; b = 0; c = 0; d = 2000 + k; x = 0; end
            4: begin a = 3000 + k; b = 1; c = -k; d = 2999 + k; x = -2 * k; end
            5: begin a = 3 * k; b = -k; c = -k; d = 4 * k; x = -2 * k; end
            6: begin a = 50 * k; b = k; c = 7; d = 49 * k; x = 14; end
            7: begin a = 9999; b = 0; c = 0; d = 9999; x = 0; end
            default: begin a = -100 - k; b = 20; c = 5; d = -120 - k; x = 10; end
        endcase
        e = {d, x};
    endtask

    // driver tasks
    task automatic idle();
        @(negedge clk);
        din_valid = 1'b0;
        rd_en = 1'b0;
        rd_done = 1'b0;
    endtask

    task automatic send_frame(input int mode, input int n, input bit gaps);
        logic [2*(DW+1)-1:0] e;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rd_en = 1'b0;
            gen(mode, k, r11, r22, r12_re, e);
            din_valid = 1'b1;
            if (gaps && k < n - 1) begin
                @(negedge clk);
                din_valid = 1'b0;
            end
        end
    endtask

    task automatic read_ch(input int mode, input int k);
        logic [DW-1:0] a, b, c;
        logic [2*(DW+1)-1:0] e;
        gen(mode, k, a, b, c, e);
        @(negedge clk);
        din_valid = 1'b0;
        rd_en = 1'b1;
        rd_addr = AW'(k);
        exp_q.push_back(e);
        iss_q.push_back(cyc);
    endtask

    task automatic read_frame(input int mode);
        for (int k = 0; k < VL; k++) read_ch(mode, k);
        repeat (4) idle();
    endtask

    task automatic release_frame();
        @(negedge clk);
        din_valid = 1'b0;
        rd_en = 1'b0;
        rd_done = 1'b1;
        @(negedge clk);
        rd_done = 1'b0;
        check("ready_after_rd_done", 66'(frame_ready), 66'(0));
    endtask

    task automatic check_state(input string nm, input logic rdy, input int fc, input int dc);
        check({nm, "_ready"}, 66'(frame_ready), 66'(rdy));
        check({nm, "_frame_count"}, 66'(frame_count), 66'(fc));
        check({nm, "_drop_count"}, 66'(drop_count), 66'(dc));
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_rd_valid"}, 66'(rd_valid), 66'(0));
        check({nm, "_rd_data"}, {rd_diff, rd_cross}, 66'(0));
        check_state(nm, 1'b0, 0, 0);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                check("rd_unexpected", 66'(1), 66'(0));
            end else begin
                check("rd_data", {rd_diff, rd_cross}, exp_q.pop_front());
                check("rd_latency", 66'(cyc - iss_q.pop_front()), 66'(2));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Basic frame and completion latency
        send_frame(0, VL, 1'b0);
        idle();
        check("ready_before_commit", 66'(frame_ready), 66'(0));
        idle();
        check_state("frame_a", 1'b1, 1, 0);
        read_frame(0);
        release_frame();

        // Arithmetic extremes
        send_frame(1, VL, 1'b0);
        repeat (2) idle();
        check_state("frame_b", 1'b1, 2, 0);
        read_ch(1, 0);
        read_ch(1, 1);
        read_ch(1, 7);
        repeat (4) idle();
        release_frame();

        // Second frame without release is dropped; held frame survives
        send_frame(2, VL, 1'b0);
        repeat (2) idle();
        check_state("frame_c", 1'b1, 3, 0);
        send_frame(3, VL, 1'b0);
        repeat (2) idle();
        check_state("frame_d_drop", 1'b1, 3, 1);
        read_frame(2);
        release_frame();
        send_frame(4, VL, 1'b0);
        repeat (2) idle();
        check_state("frame_e", 1'b1, 4, 1);
        read_frame(4);

        // rd_done coinciding with completion
        send_frame(5, VL, 1'b0);
        @(negedge clk);
        din_valid = 1'b0;
        rd_done = 1'b1;
        @(negedge clk);
        rd_done = 1'b0;
        check_state("frame_f_simul", 1'b1, 5, 1);
        read_frame(5);
        release_frame();

        // Gapped input
        send_frame(6, VL, 1'b1);
        repeat (2) idle();
        check_state("frame_g_gaps", 1'b1, 6, 1);
        read_frame(6);
        release_frame();

        // Reset mid-frame
        send_frame(7, 5, 1'b0);
        @(negedge clk);
        din_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        rst = 1'b0;
        send_frame(8, VL, 1'b0);
        repeat (2) idle();
        check_state("frame_i_post_reset", 1'b1, 1, 0);
        read_ch(8, 0);
        read_ch(8, 7);
        repeat (4) idle();

        check("scoreboard_drained", 66'(exp_q.size()), 66'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
